// File: rtl/mem_access.sv
// Memory-stage load/store engine: drives one data-RAM request per load/store,
// holds the pipeline while the access is in flight and returns an aligned, extended load value.
module mem_access #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_rdata2,
    input  logic        ex_is_ram,
    input  logic        ex_ram_we,
    input  logic [3:0]  ex_ram_wen,
    input  logic [1:0]  ex_ram_sign,
    output logic        data_req,
    output logic        data_wr,
    output logic [3:0]  data_be,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        mem_stall,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    output logic        mem_misalign,
    output logic        mem_err,
    output logic [31:0] mem_err_pc
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    state_t        state_reg, state_next;
    logic          data_req_reg, data_req_next;
    logic          data_wr_reg, data_wr_next;
    logic [3:0]    data_be_reg, data_be_next;
    logic [31:0]   data_addr_reg, data_addr_next;
    logic [31:0]   data_wdata_reg, data_wdata_next;
    logic [1:0]    lane_reg, lane_next;
    size_t         size_reg, size_next;
    logic          sign_reg, sign_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [31:0]   mem_rdata_reg, mem_rdata_next;
    logic          mem_done_reg, mem_done_next;
    logic          mem_misalign_reg, mem_misalign_next;
    logic          mem_err_reg, mem_err_next;
    logic [31:0]   mem_err_pc_reg, mem_err_pc_next;

    size_t       ex_size;
    logic [1:0]  ex_lane;
    logic [3:0]  ex_mask;
    logic [3:0]  ex_be;
    logic [31:0] ex_wdata;
    logic        ex_misalign;
    logic        start;
    logic [31:0] ld_shift;
    logic [31:0] ld_result;
    logic [31:0] resp_value;
    logic        unused_sign;

    // Bit1 of the sign field carries no meaning here.
    assign unused_sign = ex_ram_sign[1];

    // Any size mask other than byte/half is taken as a full word.
    always_comb begin
        case (ex_ram_wen)
            4'b0001: begin ex_size = SZ_BYTE; ex_mask = 4'b0001; end
            4'b0011: begin ex_size = SZ_HALF; ex_mask = 4'b0011; end
            default: begin ex_size = SZ_WORD; ex_mask = 4'b1111; end
        endcase
    end

    assign ex_lane     = ex_alu_out[1:0];
    assign ex_be       = ex_mask << ex_lane;
    assign ex_misalign = ((ex_size == SZ_HALF) && ex_lane[0]) ||
                         ((ex_size == SZ_WORD) && (ex_lane != 2'b00));
    assign start       = (state_reg == S_IDLE) && ex_is_ram;

    // Each byte lane carries byte (lane mod size) of rt, so the slave can pick any enabled lane.
    for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
        assign ex_wdata[gi*8 +: 8] = (ex_size == SZ_BYTE) ? ex_rdata2[7:0] :
                                     (ex_size == SZ_HALF) ? ex_rdata2[(gi%2)*8 +: 8] :
                                                            ex_rdata2[gi*8 +: 8];
    end

    assign ld_shift = data_rdata >> {lane_reg, 3'b000};

    always_comb begin
        case (size_reg)
            SZ_BYTE: ld_result = {{24{sign_reg & ld_shift[7]}},  ld_shift[7:0]};
            SZ_HALF: ld_result = {{16{sign_reg & ld_shift[15]}}, ld_shift[15:0]};
            default: ld_result = data_rdata;
        endcase
    end

    assign resp_value = data_wr_reg ? 32'd0 : ld_result;

    always_comb begin
        state_next        = state_reg;
        data_req_next     = data_req_reg;
        data_wr_next      = data_wr_reg;
        data_be_next      = data_be_reg;
        data_addr_next    = data_addr_reg;
        data_wdata_next   = data_wdata_reg;
        lane_next         = lane_reg;
        size_next         = size_reg;
        sign_next         = sign_reg;
        cnt_next          = cnt_reg;
        mem_rdata_next    = mem_rdata_reg;
        mem_done_next     = 1'b0;
        mem_misalign_next = 1'b0;
        mem_err_next      = 1'b0;
        mem_err_pc_next   = mem_err_pc_reg;
        case (state_reg)
            S_IDLE: begin
                if (start && ex_misalign) begin
                    mem_err_pc_next   = ex_pc;
                    mem_rdata_next    = 32'd0;
                    mem_done_next     = 1'b1;
                    mem_misalign_next = 1'b1;
                    state_next        = S_DONE;
                end else if (start) begin
                    data_req_next   = 1'b1;
                    data_wr_next    = ex_ram_we;
                    data_be_next    = ex_be;
                    data_addr_next  = {ex_alu_out[31:2], 2'b00};
                    data_wdata_next = ex_wdata;
                    lane_next       = ex_lane;
                    size_next       = ex_size;
                    sign_next       = ex_ram_sign[0];
                    state_next      = S_REQ;
                end
            end
            S_REQ: begin
                if (data_addr_ok) begin
                    data_req_next = 1'b0;
                    cnt_next      = '0;
                    if (data_data_ok) begin
                        mem_rdata_next = resp_value;
                        mem_done_next  = 1'b1;
                        state_next     = S_DONE;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // A response on the final counted cycle still wins over the timeout.
                if (data_data_ok) begin
                    mem_rdata_next = resp_value;
                    mem_done_next  = 1'b1;
                    state_next     = S_DONE;
                end else if (cnt_reg == CNT_LAST) begin
                    mem_rdata_next  = 32'd0;
                    mem_err_pc_next = ex_pc;
                    mem_err_next    = 1'b1;
                    mem_done_next   = 1'b1;
                    state_next      = S_DONE;
                end else if (cnt_reg != CNT_MAX) begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_reg        <= S_IDLE;
            data_req_reg     <= 1'b0;
            data_wr_reg      <= 1'b0;
            data_be_reg      <= 4'd0;
            data_addr_reg    <= 32'd0;
            data_wdata_reg   <= 32'd0;
            lane_reg         <= 2'd0;
            size_reg         <= SZ_BYTE;
            sign_reg         <= 1'b0;
            cnt_reg          <= '0;
            mem_rdata_reg    <= 32'd0;
            mem_done_reg     <= 1'b0;
            mem_misalign_reg <= 1'b0;
            mem_err_reg      <= 1'b0;
            mem_err_pc_reg   <= 32'd0;
        end else begin
            state_reg        <= state_next;
            data_req_reg     <= data_req_next;
            data_wr_reg      <= data_wr_next;
            data_be_reg      <= data_be_next;
            data_addr_reg    <= data_addr_next;
            data_wdata_reg   <= data_wdata_next;
            lane_reg         <= lane_next;
            size_reg         <= size_next;
            sign_reg         <= sign_next;
            cnt_reg          <= cnt_next;
            mem_rdata_reg    <= mem_rdata_next;
            mem_done_reg     <= mem_done_next;
            mem_misalign_reg <= mem_misalign_next;
            mem_err_reg      <= mem_err_next;
            mem_err_pc_reg   <= mem_err_pc_next;
        end
    end

    assign mem_stall    = !resetn && (start || (state_reg == S_REQ) || (state_reg == S_WAIT));
    assign data_req     = data_req_reg;
    assign data_wr      = data_wr_reg;
    assign data_be      = data_be_reg;
    assign data_addr    = data_addr_reg;
    assign data_wdata   = data_wdata_reg;
    assign mem_done     = mem_done_reg;
    assign mem_rdata    = mem_rdata_reg;
    assign mem_misalign = mem_misalign_reg;
    assign mem_err      = mem_err_reg;
    assign mem_err_pc   = mem_err_pc_reg;
endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access: a driver issues instructions, a bus slave answers with
// chosen latencies, and a monitor checks each completion against a queued reference result.
module tb_mem_access;
    localparam int TMO = 4;

    logic        clk;
    logic        resetn;
    logic [31:0] ex_pc, ex_alu_out, ex_rdata2;
    logic        ex_is_ram, ex_ram_we;
    logic [3:0]  ex_ram_wen;
    logic [1:0]  ex_ram_sign;
    logic        data_req, data_wr;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_stall, mem_done, mem_misalign, mem_err;
    logic [31:0] mem_rdata, mem_err_pc;

    mem_access #(.TIMEOUT(TMO)) dut (
        .clk(clk), .resetn(resetn),
        .ex_pc(ex_pc), .ex_alu_out(ex_alu_out), .ex_rdata2(ex_rdata2),
        .ex_is_ram(ex_is_ram), .ex_ram_we(ex_ram_we), .ex_ram_wen(ex_ram_wen),
        .ex_ram_sign(ex_ram_sign),
        .data_req(data_req), .data_wr(data_wr), .data_be(data_be),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_stall(mem_stall), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .mem_misalign(mem_misalign), .mem_err(mem_err), .mem_err_pc(mem_err_pc)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        err;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          alat;
        int          dlat;
        bit          same;
        bit          tmo;
        logic [31:0] rdata;
    } bus_t;

    exp_t        exp_q[$];
    bus_t        slave_q[$];
    int          total = 0;
    int          bad = 0;
    bit          slave_en = 0;
    int          stray_req = 0;
    int          stray_done = 0;
    logic [31:0] last_err_pc = 32'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference rules: access size in bytes, enables, lane replication, load extraction.
    function automatic int nbytes(input logic [3:0] wen);
        if (wen == 4'b0001) return 1;
        if (wen == 4'b0011) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] be_of(input int n, input int off);
        int m;
        m = ((1 << n) - 1) << off;
        return m[3:0];
    endfunction

    function automatic logic [31:0] rep_of(input logic [31:0] rt, input int n);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = rt[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] load_of(input logic [31:0] rd, input int off, input int n,
                                            input bit sgn);
        longint unsigned v;
        v = ({32'd0, rd} >> (8 * off)) & ((64'd1 << (8 * n)) - 64'd1);
        if (sgn && n < 4 && v >= (64'd1 << (8 * n - 1)))
            v = v + (64'd1 << 32) - (64'd1 << (8 * n));
        return v[31:0];
    endfunction

    // Present one instruction, queue its expectations and hold it until the stage advances.
    task automatic issue(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] rt,
                         input logic [31:0] rd, input logic is_ram, input logic we,
                         input logic [3:0] wen, input logic [1:0] sign,
                         input int alat, input int dlat, input bit same, input bit tmo);
        int   n, off, exp_stalls, stalls, cyc;
        bit   mis;
        exp_t e;
        bus_t b;
        ex_pc = pc; ex_alu_out = addr; ex_rdata2 = rt; ex_is_ram = is_ram;
        ex_ram_we = we; ex_ram_wen = wen; ex_ram_sign = sign;
        n   = nbytes(wen);
        off = int'(addr[1:0]);
        mis = (off % n) != 0;
        exp_stalls = 0;
        if (is_ram && mis) begin
            last_err_pc = pc;
            e = '{32'd0, 1'b1, 1'b0, pc};
            exp_q.push_back(e);
            exp_stalls = 1;
        end else if (is_ram) begin
            b = '{we, be_of(n, off), {addr[31:2], 2'b00}, rep_of(rt, n), alat, dlat, same, tmo, rd};
            slave_q.push_back(b);
            if (tmo) begin
                last_err_pc = pc;
                e = '{32'd0, 1'b0, 1'b1, pc};
                exp_stalls = 1 + alat + 1 + TMO;
            end else begin
                e = '{we ? 32'd0 : load_of(rd, off, n, sign[0]), 1'b0, 1'b0, last_err_pc};
                exp_stalls = 1 + alat + 1 + (same ? 0 : dlat + 1);
            end
            exp_q.push_back(e);
        end
        #1;
        stalls = 0;
        cyc = 0;
        while (mem_stall && cyc < 100) begin
            stalls++;
            @(negedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 100) begin
            $display("FAIL stall_bound: pc=%h still stalled after %0d cycles", pc, cyc);
            $fatal(1, "stall never released");
        end
        total++;
        if (stalls != exp_stalls) begin
            bad++;
            $display("FAIL stall_count: pc=%h got %0d want %0d", pc, stalls, exp_stalls);
        end
        $display("txn pc=%h addr=%h ram=%0b we=%0b wen=%b stalls=%0d", pc, addr, is_ram, we, wen, stalls);
        @(negedge clk);
    endtask

    // Bus slave: checks fields while the request is held, then answers per the queued latencies.
    initial begin
        bus_t s;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'd0;
        forever begin
            @(negedge clk);
            if (stray_req != stray_done) begin
                stray_done++;
                data_data_ok = 1'b1;
                data_rdata   = $urandom;
                @(negedge clk);
                data_data_ok = 1'b0;
            end else if (slave_en && data_req === 1'b1) begin
                if (slave_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_req: got req addr=%h want no request", data_addr);
                end else begin
                    s = slave_q.pop_front();
                    for (int i = 0; i <= s.alat; i++) begin
                        if (i > 0) @(negedge clk);
                        total++;
                        if (data_req !== 1'b1 ||
                            {data_wr, data_be, data_addr, data_wdata} !== {s.wr, s.be, s.addr, s.wdata}) begin
                            bad++;
                            $display("FAIL bus_fields: got req=%b wr=%b be=%b addr=%h wd=%h want req=1 wr=%b be=%b addr=%h wd=%h",
                                     data_req, data_wr, data_be, data_addr, data_wdata,
                                     s.wr, s.be, s.addr, s.wdata);
                        end
                    end
                    data_addr_ok = 1'b1;
                    if (s.same) begin
                        data_data_ok = 1'b1;
                        data_rdata   = s.rdata;
                    end
                    @(negedge clk);
                    data_addr_ok = 1'b0;
                    data_data_ok = 1'b0;
                    data_rdata   = $urandom;
                    total++;
                    if (data_req !== 1'b0) begin
                        bad++;
                        $display("FAIL req_drop: got req=%b want 0", data_req);
                    end
                    if (!s.same && !s.tmo) begin
                        repeat (s.dlat) @(negedge clk);
                        data_data_ok = 1'b1;
                        data_rdata   = s.rdata;
                        @(negedge clk);
                        data_data_ok = 1'b0;
                        data_rdata   = $urandom;
                    end
                end
            end
        end
    end

    // Monitor: every completion is matched against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_done === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done: got mem_done=1 want 0");
                end else begin
                    e = exp_q.pop_front();
                    if ({mem_rdata, mem_misalign, mem_err, mem_err_pc} !== {e.rdata, e.mis, e.err, e.pc}) begin
                        bad++;
                        $display("FAIL done_result: got rd=%h mis=%b err=%b epc=%h want rd=%h mis=%b err=%b epc=%h",
                                 mem_rdata, mem_misalign, mem_err, mem_err_pc, e.rdata, e.mis, e.err, e.pc);
                    end
                end
            end else begin
                total++;
                if (mem_misalign !== 1'b0 || mem_err !== 1'b0) begin
                    bad++;
                    $display("FAIL flag_no_done: got mis=%b err=%b want 0 0", mem_misalign, mem_err);
                end
            end
        end
    end

    initial begin
        logic [31:0] a, pc, rt, rd;
        logic [3:0]  wen;
        int          n;
        resetn = 1'b1;
        ex_pc = 32'd0; ex_alu_out = 32'd0; ex_rdata2 = 32'd0; ex_is_ram = 1'b1;
        ex_ram_we = 1'b0; ex_ram_wen = 4'b1111; ex_ram_sign = 2'b00;
        repeat (3) @(negedge clk);
        total++;
        if ({data_req, data_wr, data_be, data_addr, data_wdata, mem_rdata, mem_done,
             mem_misalign, mem_err, mem_err_pc, mem_stall} !== '0) begin
            bad++;
            $display("FAIL reset_state: got req=%b wr=%b be=%b addr=%h wd=%h rd=%h done=%b epc=%h stall=%b want all 0",
                     data_req, data_wr, data_be, data_addr, data_wdata, mem_rdata, mem_done, mem_err_pc, mem_stall);
        end
        ex_is_ram = 1'b0;
        resetn = 1'b0;
        slave_en = 1'b1;

        for (int i = 0; i < 10; i++) begin
            ex_alu_out = $urandom;
            ex_ram_we  = 1'($urandom);
            @(negedge clk);
            #1;
            total++;
            if (mem_stall !== 1'b0 || data_req !== 1'b0) begin
                bad++;
                $display("FAIL non_mem: got stall=%b req=%b want 0 0", mem_stall, data_req);
            end
        end
        @(negedge clk);

        // Directed: pc, addr, rt, rdata, ram, we, wen, sign, addr_lat, data_lat, same, timeout
        issue(32'h100, 32'h1003, 32'h12345678, 32'h80112233, 1, 0, 4'b0001, 2'b01, 2, 0, 0, 0);
        issue(32'h104, 32'h2002, 32'h0000BEEF, 32'h0,        1, 1, 4'b0011, 2'b00, 3, 1, 0, 0);
        issue(32'h400, 32'h3001, 32'h0,        32'h0,        1, 0, 4'b1111, 2'b00, 0, 0, 0, 0);
        issue(32'h108, 32'h4000, 32'h0,        32'hDEADBEEF, 1, 0, 4'b1111, 2'b00, 0, 0, 0, 1);
        issue(32'h10C, 32'h5008, 32'h0,        32'hCAFEF00D, 1, 0, 4'b1111, 2'b00, 0, 0, 1, 0);
        issue(32'h110, 32'h6002, 32'h0,        32'h9ABC1234, 1, 0, 4'b0011, 2'b01, 1, 3, 0, 0);
        issue(32'h114, 32'h7003, 32'h0,        32'h7F00FF00, 1, 0, 4'b0001, 2'b00, 0, 0, 0, 0);
        issue(32'h118, 32'h7004, 32'hA1B2C3D4, 32'h0,        1, 1, 4'b0101, 2'b00, 0, 2, 0, 0);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: wen = 4'b0001;
                1: wen = 4'b0011;
                2: wen = 4'b1111;
                default: wen = 4'($urandom);
            endcase
            n  = nbytes(wen);
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & ~32'(n - 1);
            pc = {$urandom_range(0, 65535), 2'b00};
            rt = $urandom;
            rd = $urandom;
            issue(pc, a, rt, rd, ($urandom_range(0, 6) != 0), 1'($urandom), wen, 2'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0));
        end

        total++;
        if (exp_q.size() != 0 || slave_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got exp=%0d bus=%0d pending want 0 0", exp_q.size(), slave_q.size());
        end

        // Reset in the middle of a request, then a late response that must be ignored.
        slave_en = 1'b0;
        ex_pc = 32'h900; ex_alu_out = 32'h7000_0010; ex_is_ram = 1'b1;
        ex_ram_we = 1'b0; ex_ram_wen = 4'b1111;
        @(negedge clk);
        total++;
        if (data_req !== 1'b1) begin
            bad++;
            $display("FAIL rst_req_up: got req=%b want 1", data_req);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if ({data_req, data_wr, data_be, data_addr, data_wdata, mem_rdata, mem_done,
             mem_misalign, mem_err, mem_err_pc, mem_stall} !== '0) begin
            bad++;
            $display("FAIL rst_mid: got req=%b be=%b addr=%h rd=%h done=%b epc=%h stall=%b want all 0",
                     data_req, data_be, data_addr, mem_rdata, mem_done, mem_err_pc, mem_stall);
        end
        resetn = 1'b0;
        ex_is_ram = 1'b0;
        last_err_pc = 32'd0;
        stray_req++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            total++;
            if (mem_done !== 1'b0 || data_req !== 1'b0) begin
                bad++;
                $display("FAIL late_resp: got done=%b req=%b want 0 0", mem_done, data_req);
            end
        end
        slave_en = 1'b1;
        @(negedge clk);
        issue(32'h904, 32'h8001, 32'h0, 32'h11223344, 1, 0, 4'b0001, 2'b01, 1, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
